// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions: pointer width plus Gray/popcount helpers
// used on both sides of the clock crossing.
package fifo_pkg;

  localparam int ADDR_W = 5;

  // Inverse of BinaryToGray: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_W-1:0] gray2bin(input logic [ADDR_W-1:0] g);
    logic [ADDR_W-1:0] b;
    b[ADDR_W-1] = g[ADDR_W-1];
    for (int i = ADDR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [ADDR_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < ADDR_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter, counterpart of BinaryToGray.
module gray_to_binary #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Reduction per bit rather than a ripple chain keeps the net graph acyclic.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bin[gi] = ^gray[W-1:gi];
  end

endmodule

// File: rtl/w2r_ptr_sync.sv
// Read-domain receiver for the FIFO write pointer: Gray synchronizer, binary
// conversion, read occupancy, almost-empty and a sticky Gray-coherency flag.
module w2r_ptr_sync
  import fifo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              r_clk,
  input  logic              r_reset,
  input  logic [ADDR_W-1:0] w_add_gray_async,
  input  logic [ADDR_W-1:0] r_add,
  input  logic              gray_err_clr,
  output logic [ADDR_W-1:0] w_add_synched,
  output logic [ADDR_W-1:0] rd_level,
  output logic              almost_empty,
  output logic              sync_valid,
  output logic              gray_err
);

  localparam logic [2:0]        WARM_MAX = 3'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] AE_LIM   = ADDR_W'(AE_THRESH);

  logic [ADDR_W-1:0] stage_reg [SYNC_STAGES];
  logic [ADDR_W-1:0] sync_last;
  logic [ADDR_W-1:0] bin_next;
  logic [ADDR_W-1:0] w_add_reg;
  logic [ADDR_W-1:0] level_reg;
  logic [ADDR_W-1:0] level_next;
  logic [ADDR_W-1:0] prev_g_reg;
  logic [2:0]        warm_reg;
  logic              ae_reg;
  logic              err_reg;
  logic              err_set;

  // Bare flop chain: nothing may sit between stages so each can resolve.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) stage_reg[gi] <= '0;
        else         stage_reg[gi] <= w_add_gray_async;
      end
    end else begin : g_rest
      always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) stage_reg[gi] <= '0;
        else         stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign sync_last = stage_reg[SYNC_STAGES-1];

  gray_to_binary #(.W(ADDR_W)) u_g2b (
    .gray (sync_last),
    .bin  (bin_next)
  );

  assign level_next = w_add_reg - r_add;
  assign sync_valid = (warm_reg == WARM_MAX);
  assign err_set    = sync_valid && (popcount(prev_g_reg ^ sync_last) > 1);

  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      w_add_reg  <= '0;
      level_reg  <= '0;
      ae_reg     <= 1'b1;
      prev_g_reg <= '0;
      warm_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      w_add_reg  <= bin_next;
      level_reg  <= level_next;
      ae_reg     <= (level_next <= AE_LIM);
      prev_g_reg <= sync_last;
      if (warm_reg != WARM_MAX) warm_reg <= warm_reg + 3'd1;
      // A fresh violation outranks a clear arriving in the same cycle.
      if (err_set)           err_reg <= 1'b1;
      else if (gray_err_clr) err_reg <= 1'b0;
    end
  end

  assign w_add_synched = w_add_reg;
  assign rd_level      = level_reg;
  assign almost_empty  = ae_reg;
  assign gray_err      = err_reg;

endmodule

// File: tb/tb_w2r_ptr_sync.sv
// Directed bench for w2r_ptr_sync: latency, level wrap, coherency flag, async reset.
module tb_w2r_ptr_sync;

  logic       r_clk = 1'b0;
  logic       r_reset;
  logic [4:0] w_add_gray_async;
  logic [4:0] r_add;
  logic       gray_err_clr;
  logic [4:0] w_add_synched;
  logic [4:0] rd_level;
  logic       almost_empty;
  logic       sync_valid;
  logic       gray_err;

  int total = 0;
  int bad   = 0;

  logic [4:0] gray_tab [5] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6};

  w2r_ptr_sync #(.SYNC_STAGES(2), .AE_THRESH(2)) dut (
    .r_clk            (r_clk),
    .r_reset          (r_reset),
    .w_add_gray_async (w_add_gray_async),
    .r_add            (r_add),
    .gray_err_clr     (gray_err_clr),
    .w_add_synched    (w_add_synched),
    .rd_level         (rd_level),
    .almost_empty     (almost_empty),
    .sync_valid       (sync_valid),
    .gray_err         (gray_err)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("pass %s val=%0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_w"},   32'(w_add_synched), 32'd0);
    check({tag, "_lvl"}, 32'(rd_level),      32'd0);
    check({tag, "_ae"},  32'(almost_empty),  32'd1);
    check({tag, "_sv"},  32'(sync_valid),    32'd0);
    check({tag, "_err"}, 32'(gray_err),      32'd0);
  endtask

  initial begin
    r_reset          = 1'b1;
    w_add_gray_async = 5'd0;
    r_add            = 5'd0;
    gray_err_clr     = 1'b0;

    // Reset release, input 0: valid rises on the third edge.
    step(2);
    check_reset_vals("rst_hold");
    r_reset = 1'b0;
    step(2);
    check("warm_e2_sv", 32'(sync_valid), 32'd0);
    step(1);
    check("warm_e3_sv", 32'(sync_valid), 32'd1);
    check("warm_e3_w",  32'(w_add_synched), 32'd0);
    check("warm_e3_ae", 32'(almost_empty), 32'd1);
    check("warm_e3_err", 32'(gray_err), 32'd0);

    // Step through binary 1..4: w follows 3 edges later, level one edge after that.
    for (int k = 1; k < 5; k++) begin
      w_add_gray_async = gray_tab[k];
      step(2);
      check($sformatf("step%0d_w_e2", k), 32'(w_add_synched), 32'(k - 1));
      step(1);
      check($sformatf("step%0d_w_e3", k), 32'(w_add_synched), 32'(k));
      step(1);
      check($sformatf("step%0d_lvl", k), 32'(rd_level), 32'(k));
      check($sformatf("step%0d_ae", k), 32'(almost_empty), (k <= 2) ? 32'd1 : 32'd0);
    end
    check("step_err", 32'(gray_err), 32'd0);

    // Fresh start at 0, then a 2-bit jump 0 -> 3.
    r_reset = 1'b1;
    w_add_gray_async = 5'd0;
    #2;
    r_reset = 1'b0;
    step(5);
    w_add_gray_async = 5'd3;
    step(2);
    check("jump_e2_err", 32'(gray_err), 32'd0);
    step(1);
    check("jump_e3_err", 32'(gray_err), 32'd1);
    check("jump_w", 32'(w_add_synched), 32'd2);
    step(2);
    check("jump_sticky", 32'(gray_err), 32'd1);
    gray_err_clr = 1'b1;
    step(1);
    check("clr_err", 32'(gray_err), 32'd0);

    // Clear held while another 2-bit jump (3 -> 0) lands: set wins.
    w_add_gray_async = 5'd0;
    step(2);
    check("setwin_e2", 32'(gray_err), 32'd0);
    step(1);
    check("setwin_e3", 32'(gray_err), 32'd1);
    step(1);
    check("setwin_after", 32'(gray_err), 32'd0);
    gray_err_clr = 1'b0;

    // Wrap: Gray(30)=17, Gray(31)=16, Gray(0)=0, Gray(1)=1 against r_add=30.
    r_reset = 1'b1;
    w_add_gray_async = 5'd17;
    r_add = 5'd30;
    #2;
    r_reset = 1'b0;
    step(5);
    check("wrap30_w",   32'(w_add_synched), 32'd30);
    check("wrap30_lvl", 32'(rd_level), 32'd0);
    w_add_gray_async = 5'd16;
    step(4);
    check("wrap31_lvl", 32'(rd_level), 32'd1);
    w_add_gray_async = 5'd0;
    step(4);
    check("wrap0_lvl", 32'(rd_level), 32'd2);
    w_add_gray_async = 5'd1;
    step(4);
    check("wrap1_lvl", 32'(rd_level), 32'd3);
    check("wrap1_ae",  32'(almost_empty), 32'd0);
    check("wrap_err",  32'(gray_err), 32'd0);

    // Drive to binary 17 (Gray 25), then assert reset between edges.
    w_add_gray_async = 5'd25;
    step(5);
    check("pre_rst_w",   32'(w_add_synched), 32'd17);
    check("pre_rst_lvl", 32'(rd_level), 32'd19);
    #3;
    r_reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    step(1);
    r_reset = 1'b0;
    step(2);
    check("rearm_e2_sv", 32'(sync_valid), 32'd0);
    step(1);
    check("rearm_e3_sv", 32'(sync_valid), 32'd1);
    check("rearm_w",     32'(w_add_synched), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
